tholin_5401_bus_responder: RTL



---
 rtl/tholin_5401_bus_responder_pkg.sv | 29 ++
 rtl/tholin_5401_bus_responder_if.sv | 15 +
 rtl/tholin_5401_bus_responder_nibble_mem.sv | 29 ++
 rtl/tholin_5401_bus_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tholin_5401_bus_responder_pkg.sv
// Shared definitions for the 5401 bus responder.
//   - Op codes carried in bus_out[7:5].
//   - Bit positions of the bus fields.
//   - Read FSM state encoding.
//   - Odd-parity helper used when TH5401_RESP_PARITY_EN is defined.
package tholin_5401_bus_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_ADDR_LD  = 3'd1;
    localparam logic [2:0] OP_RD       = 3'd2;
    localparam logic [2:0] OP_WR       = 3'd3;
    localparam logic [2:0] OP_ADDR_CLR = 3'd4;
    localparam logic [2:0] OP_FLAG_CLR = 3'd5;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 5;
    localparam int STB_BIT = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Odd parity: 1 when the nibble holds an even number of ones.
    function automatic logic odd_parity(input logic [3:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/tholin_5401_bus_responder_if.sv
// Bus between the 5401 CPU and the nibble responder.
//   bus_out : CPU -> responder, {op[7:5], STB[4], payload[3:0]}
//   data_in : responder -> CPU, read nibble
//   EF0     : responder -> CPU, ready (1 = idle)
//   EF1     : responder -> CPU, wrap flag or data parity
// master = CPU side, slave = responder side.
interface tholin_5401_bus_responder_if;
    logic [7:0] bus_out;
    logic [3:0] data_in;
    logic       EF0;
    logic       EF1;

    modport master (output bus_out, input data_in, input EF0, input EF1);
    modport slave  (input bus_out, output data_in, output EF0, output EF1);
endinterface

// File: rtl/tholin_5401_bus_responder_nibble_mem.sv
// 2^ADDR_W x 4 nibble store: synchronous write, combinational read.
// Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : shared read/write address
//   wdata_i : write nibble
//   rdata_o : nibble at addr_i
module tholin_5401_nibble_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        wdata_i,
    output logic [3:0]        rdata_o
);

    logic [3:0] mem_q [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/tholin_5401_bus_responder.sv
// Nibble-memory responder on the 5401 CPU output bus.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : slave side of tholin_5401_bus_responder_if
// Optional macro TH5401_RESP_PARITY_EN: EF1 carries odd parity of data_in
// instead of the sticky address-wrap flag.
module tholin_5401_bus_responder
    import tholin_5401_bus_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    tholin_5401_bus_responder_if.slave   bus
);

    logic [2:0]        op_s;
    logic [3:0]        payload_s;
    logic              stb_evt_s;
    logic              stb_q;
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc_s;
    logic              inc_carry_s;
    logic [3:0]        data_q, data_d;
    logic              ef0_q, ef1_q, ef1_d;
    logic [3:0]        mem_rdata_s;
    logic              rd_start_s, rd_done_s, wr_en_s, ld_en_s, aclr_en_s, fclr_en_s;

    assign op_s      = bus.bus_out[OP_HI:OP_LO];
    assign payload_s = bus.bus_out[3:0];
    // Rising edge of STB; a held strobe yields a single event.
    assign stb_evt_s = bus.bus_out[STB_BIT] & ~stb_q;
    assign {inc_carry_s, addr_inc_s} = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

    tholin_5401_nibble_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_en_s),
        .addr_i  (addr_q),
        .wdata_i (payload_s),
        .rdata_o (mem_rdata_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: BUSY exits when the latency counter has run out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (stb_evt_s && (op_s == OP_RD)) state_d = S_BUSY;
                else                               state_d = S_IDLE;
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               state_d = S_BUSY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: command decode only in IDLE, so strobes while BUSY are dropped.
    always_comb begin
        rd_start_s = 1'b0;
        rd_done_s  = 1'b0;
        wr_en_s    = 1'b0;
        ld_en_s    = 1'b0;
        aclr_en_s  = 1'b0;
        fclr_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (stb_evt_s) begin
                    case (op_s)
                        OP_ADDR_LD:  ld_en_s    = 1'b1;
                        OP_RD:       rd_start_s = 1'b1;
                        OP_WR:       wr_en_s    = 1'b1;
                        OP_ADDR_CLR: aclr_en_s  = 1'b1;
                        OP_FLAG_CLR: fclr_en_s  = 1'b1;
                        default:     rd_start_s = 1'b0;
                    endcase
                end else begin
                    rd_start_s = 1'b0;
                end
            end
            S_BUSY: rd_done_s = (cnt_q == 4'd0);
            default: rd_done_s = 1'b0;
        endcase
    end

    // Datapath next state: address, latency counter, read data.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (rd_start_s) begin
            cnt_d = 4'(READ_LAT - 1);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (rd_done_s) begin
            data_d = mem_rdata_s;
            addr_d = addr_inc_s;
        end else if (wr_en_s) begin
            addr_d = addr_inc_s;
        end else if (ld_en_s) begin
            // Shift the nibble in from the bottom; the top nibble falls off.
            addr_d = ADDR_W'({addr_q, payload_s});
        end else if (aclr_en_s) begin
            addr_d = {ADDR_W{1'b0}};
        end else begin
            addr_d = addr_q;
        end
    end

    // EF1 next value: parity of the outgoing data, or the sticky wrap flag.
    always_comb begin
        ef1_d = ef1_q;
`ifdef TH5401_RESP_PARITY_EN
        ef1_d = odd_parity(data_d);
`else
        if (aclr_en_s || fclr_en_s) begin
            ef1_d = 1'b0;
        end else if ((rd_done_s || wr_en_s) && inc_carry_s) begin
            ef1_d = 1'b1;
        end else begin
            ef1_d = ef1_q;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stb_q  <= 1'b0;
            cnt_q  <= 4'd0;
            addr_q <= {ADDR_W{1'b0}};
            data_q <= 4'd0;
            ef0_q  <= 1'b1;
`ifdef TH5401_RESP_PARITY_EN
            ef1_q  <= 1'b1;
`else
            ef1_q  <= 1'b0;
`endif
        end else begin
            stb_q  <= bus.bus_out[STB_BIT];
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ef0_q  <= (state_d == S_IDLE);
            ef1_q  <= ef1_d;
        end
    end

    assign bus.data_in = data_q;
    assign bus.EF0     = ef0_q;
    assign bus.EF1     = ef1_q;

endmodule
